// File: rtl/uart_line_engine_pkg.sv
// Shared encodings for the UART line engine: FSM states, response modes and
// the control characters the line parser reacts to.
package uart_line_pkg;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_RECV,
    ST_DRAIN,
    ST_RESP,
    ST_TERM
  } state_e;

  typedef enum logic [1:0] {
    MODE_ECHO  = 2'd0,
    MODE_REV   = 2'd1,
    MODE_PAT   = 2'd2,
    MODE_ECHO3 = 2'd3
  } mode_e;

  localparam logic [7:0] CHAR_CR  = 8'h0D;
  localparam logic [7:0] CHAR_LF  = 8'h0A;
  localparam logic [7:0] CHAR_BS  = 8'h08;
  localparam logic [7:0] CHAR_DEL = 8'h7F;
  localparam logic [7:0] CHAR_SP  = 8'h20;

endpackage

// File: rtl/uart_line_engine_if.sv
// Bundle between the line engine and its uart_rx/uart_tx neighbours plus status.
// master = the surrounding system, slave = the engine itself.
interface uart_line_engine_if #(
  parameter int DATA_W   = 8,
  parameter int LINE_MAX = 128
);
  localparam int LW = $clog2(LINE_MAX + 1);

  logic              rx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              tx_busy;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic [1:0]        mode;
  logic              line_done;
  logic [LW-1:0]     line_len;
  logic              overflow;
  logic              rx_lost;

  modport master (
    output rx_ready, rx_data, tx_busy, mode,
    input  tx_start, tx_data, line_done, line_len, overflow, rx_lost
  );

  modport slave (
    input  rx_ready, rx_data, tx_busy, mode,
    output tx_start, tx_data, line_done, line_len, overflow, rx_lost
  );

endinterface

// File: rtl/uart_line_engine_ram.sv
// Line buffer: single-port synchronous RAM with write enable and a registered
// read port (one cycle read latency).
module line_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/uart_line_engine.sv
// Line-oriented UART front end: echoes and buffers a line, then answers with an
// echoed, reversed or generated line followed by CR LF. Define UART_LINE_EDIT_EN for backspace editing.
module uart_line_engine
  import uart_line_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int LINE_MAX    = 128,
  parameter int PAT_LEN     = 28,
  parameter int PAT_BASE    = 64,
  parameter int STARTUP_CYC = 32768
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_line_engine_if.slave  bus
);

  localparam int AW = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;
  localparam int LW = $clog2(LINE_MAX + 1);
  localparam int PW = $clog2(PAT_LEN + 2);
  localparam int RW = (LW > PW) ? LW : PW;
  localparam int CW = $clog2(STARTUP_CYC + 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [LW-1:0]     len_q, len_d;
  logic [1:0]        echo_cnt_q, echo_cnt_d;
  logic [DATA_W-1:0] echo_data_q, echo_data_d;
  logic              tx_start_q, tx_start_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              start_d_q;
  logic [1:0]        mode_q, mode_d;
  logic [RW-1:0]     resp_len_q, resp_len_d;
  logic [RW-1:0]     idx_q, idx_d;
  logic              prefetch_q, prefetch_d;
  logic              term_lf_q, term_lf_d;
  logic              line_done_q, line_done_d;
  logic [LW-1:0]     line_len_q, line_len_d;
  logic              overflow_q, overflow_d;
  logic              rx_lost_q, rx_lost_d;
`ifdef UART_LINE_EDIT_EN
  logic              echo_bs_q, echo_bs_d;
`endif

  logic              slot_free;
  logic              rx_is_eol;
  logic [DATA_W-1:0] echo_char;
  logic [RW-1:0]     resp_len_sel;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  line_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (LINE_MAX),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (bus.rx_data),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    echo_cnt_d   = echo_cnt_q;
    echo_data_d  = echo_data_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    mode_d       = mode_q;
    resp_len_d   = resp_len_q;
    idx_d        = idx_q;
    prefetch_d   = prefetch_q;
    term_lf_d    = term_lf_q;
    line_done_d  = 1'b0;
    line_len_d   = line_len_q;
    overflow_d   = overflow_q;
    rx_lost_d    = rx_lost_q;
    ram_we       = 1'b0;
    resp_len_sel = RW'(len_q);
`ifdef UART_LINE_EDIT_EN
    echo_bs_d    = echo_bs_q;
    echo_char    = !echo_bs_q ? echo_data_q :
                   (echo_cnt_q == 2'd2) ? DATA_W'(CHAR_SP) : DATA_W'(CHAR_BS);
`else
    echo_char    = echo_data_q;
`endif

    slot_free = !bus.tx_busy && !tx_start_q && !start_d_q;
    rx_is_eol = (bus.rx_data == DATA_W'(CHAR_CR)) || (bus.rx_data == DATA_W'(CHAR_LF));

    // The RAM port is shared: RESP reads (possibly mirrored), everything else writes at len.
    if (state_q == ST_RESP) begin
      if (mode_q == MODE_REV) begin
        ram_addr = AW'(len_q - LW'(1) - LW'(idx_q));
      end else begin
        ram_addr = AW'(idx_q);
      end
    end else begin
      ram_addr = len_q[AW-1:0];
    end

    // tx_data is only meaningful alongside tx_start; it parks at zero once the slot is idle.
    if (slot_free) begin
      tx_data_d = '0;
    end

    if ((state_q == ST_RECV || state_q == ST_DRAIN) && echo_cnt_q != 2'd0 && slot_free) begin
      tx_start_d = 1'b1;
      tx_data_d  = echo_char;
      echo_cnt_d = echo_cnt_q - 2'd1;
    end

    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (32'(cnt_q) + 32'd1 >= 32'(STARTUP_CYC)) begin
          cnt_d      = '0;
          state_d    = ST_RECV;
          overflow_d = 1'b0;
          rx_lost_d  = 1'b0;
        end
      end

      ST_RECV: begin
        if (bus.rx_ready) begin
          if (rx_is_eol) begin
            if (len_q != '0) begin
              state_d = ST_DRAIN;
            end
`ifdef UART_LINE_EDIT_EN
          end else if (bus.rx_data == DATA_W'(CHAR_BS) || bus.rx_data == DATA_W'(CHAR_DEL)) begin
            if (len_q != '0) begin
              len_d = len_q - LW'(1);
              if (echo_cnt_q == 2'd0) begin
                echo_cnt_d = 2'd3;
                echo_bs_d  = 1'b1;
              end
            end
`endif
          end else if (len_q < LW'(LINE_MAX)) begin
            ram_we = 1'b1;
            len_d  = len_q + LW'(1);
            // A byte arriving while an echo is still owed is stored but not echoed.
            if (echo_cnt_q == 2'd0) begin
              echo_cnt_d  = 2'd1;
              echo_data_d = bus.rx_data;
`ifdef UART_LINE_EDIT_EN
              echo_bs_d   = 1'b0;
`endif
            end
          end else begin
            overflow_d = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        if (echo_cnt_q == 2'd0 && slot_free) begin
          if (bus.mode == MODE_PAT) begin
            resp_len_sel = RW'(PAT_LEN);
          end
          mode_d     = bus.mode;
          resp_len_d = resp_len_sel;
          idx_d      = '0;
          prefetch_d = 1'b0;
          term_lf_d  = 1'b0;
          state_d    = (resp_len_sel == '0) ? ST_TERM : ST_RESP;
        end
      end

      ST_RESP: begin
        // prefetch_q marks that ram_rdata already holds the character for idx_q.
        prefetch_d = 1'b1;
        if (slot_free && (mode_q == MODE_PAT || prefetch_q)) begin
          tx_start_d = 1'b1;
          tx_data_d  = (mode_q == MODE_PAT) ? DATA_W'(PAT_BASE) + DATA_W'(idx_q) : ram_rdata;
          prefetch_d = 1'b0;
          if (idx_q == resp_len_q - RW'(1)) begin
            state_d   = ST_TERM;
            term_lf_d = 1'b0;
          end else begin
            idx_d = idx_q + RW'(1);
          end
        end
      end

      ST_TERM: begin
        if (slot_free) begin
          tx_start_d = 1'b1;
          if (!term_lf_q) begin
            tx_data_d = DATA_W'(CHAR_CR);
            term_lf_d = 1'b1;
          end else begin
            tx_data_d   = DATA_W'(CHAR_LF);
            line_done_d = 1'b1;
            line_len_d  = len_q;
            len_d       = '0;
            state_d     = ST_RECV;
            overflow_d  = 1'b0;
            rx_lost_d   = 1'b0;
          end
        end
      end

      default: state_d = ST_WAIT;
    endcase

    if (bus.rx_ready && state_q != ST_RECV) begin
      rx_lost_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT;
      cnt_q       <= '0;
      len_q       <= '0;
      echo_cnt_q  <= '0;
      echo_data_q <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      start_d_q   <= 1'b0;
      mode_q      <= '0;
      resp_len_q  <= '0;
      idx_q       <= '0;
      prefetch_q  <= 1'b0;
      term_lf_q   <= 1'b0;
      line_done_q <= 1'b0;
      line_len_q  <= '0;
      overflow_q  <= 1'b0;
      rx_lost_q   <= 1'b0;
`ifdef UART_LINE_EDIT_EN
      echo_bs_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      echo_cnt_q  <= echo_cnt_d;
      echo_data_q <= echo_data_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      start_d_q   <= tx_start_q;
      mode_q      <= mode_d;
      resp_len_q  <= resp_len_d;
      idx_q       <= idx_d;
      prefetch_q  <= prefetch_d;
      term_lf_q   <= term_lf_d;
      line_done_q <= line_done_d;
      line_len_q  <= line_len_d;
      overflow_q  <= overflow_d;
      rx_lost_q   <= rx_lost_d;
`ifdef UART_LINE_EDIT_EN
      echo_bs_q   <= echo_bs_d;
`endif
    end
  end

  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.line_done = line_done_q;
  assign bus.line_len  = line_len_q;
  assign bus.overflow  = overflow_q;
  assign bus.rx_lost   = rx_lost_q;

endmodule
